// File: rtl/beep_sequencer.sv
// Beep pattern generator: a START pulse plays BEEP_COUNT tone bursts of ON_TICKS
// CE ticks, separated by OFF_TICKS-tick silent gaps; the tone is divided from CLK.
module beep_sequencer #(
  parameter int CNT_BITS   = 8,
  parameter int BEEP_COUNT = 3,
  parameter int ON_TICKS   = 50,
  parameter int OFF_TICKS  = 50,
  parameter int TONE_DIV   = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       START,
  input  logic       STOP,
  output logic       BUZ,
  output logic       LED,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_BITS-1:0] BEEP_LOAD = CNT_BITS'(BEEP_COUNT - 1);
  localparam logic [CNT_BITS-1:0] ON_LOAD   = CNT_BITS'(ON_TICKS - 1);
  localparam logic [CNT_BITS-1:0] OFF_LOAD  = CNT_BITS'(OFF_TICKS - 1);
  localparam logic [CNT_BITS-1:0] TONE_LOAD = CNT_BITS'(TONE_DIV - 1);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] beep_q, beep_d;
  logic [CNT_BITS-1:0] tick_q, tick_d;
  logic [CNT_BITS-1:0] tone_q, tone_d;
  logic                buz_q, buz_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // START and STOP are single-cycle pulses sampled on every CLK edge; no
  // acknowledge exists. STOP outranks START, and START outranks the timed flow.
  always_comb begin
    state_d = state_q;
    beep_d  = beep_q;
    tick_d  = tick_q;
    tone_d  = tone_q;
    buz_d   = 1'b0;
    done_d  = 1'b0;
    if (STOP) begin
      state_d = S_IDLE;
    end else if (START) begin
      state_d = S_ON;
      beep_d  = BEEP_LOAD;
      tick_d  = ON_LOAD;
      tone_d  = TONE_LOAD;
    end else begin
      case (state_q)
        S_ON: begin
          if (tone_q == '0) begin
            buz_d  = ~buz_q;
            tone_d = TONE_LOAD;
          end else begin
            buz_d  = buz_q;
            tone_d = tone_q - 1'b1;
          end
          if (CE) begin
            if (tick_q != '0) begin
              tick_d = tick_q - 1'b1;
            end else if (beep_q != '0) begin
              state_d = S_OFF;
              tick_d  = OFF_LOAD;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        S_OFF: begin
          if (CE) begin
            if (tick_q != '0) begin
              tick_d = tick_q - 1'b1;
            end else begin
              state_d = S_ON;
              beep_d  = beep_q - 1'b1;
              tick_d  = ON_LOAD;
              tone_d  = TONE_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
    // The tone only sounds while the next state is ON, so every exit or
    // (re)entry into ON starts the square wave from 0.
    if (state_d != S_ON) buz_d = 1'b0;
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      beep_q  <= '0;
      tick_q  <= '0;
      tone_q  <= '0;
      buz_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beep_q  <= beep_d;
      tick_q  <= tick_d;
      tone_q  <= tone_d;
      buz_q   <= buz_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUZ       = buz_q;
  assign LED       = led_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: two parameterisations share the stimulus; per-cycle
// waveform tables are expanded into vectors and checked through an expected queue.
module tb_beep_sequencer;

  logic       clk, clr, ce, start, stop;
  logic       buz_a, led_a, busy_a, done_a;
  logic       buz_b, led_b, busy_b, done_b;
  logic [1:0] st_a, st_b;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  beep_sequencer #(.CNT_BITS(8), .BEEP_COUNT(2), .ON_TICKS(3), .OFF_TICKS(2), .TONE_DIV(2)) dut_a (
    .CLK(clk), .CLR(clr), .CE(ce), .START(start), .STOP(stop),
    .BUZ(buz_a), .LED(led_a), .BUSY(busy_a), .DONE(done_a), .DBG_STATE(st_a)
  );

  beep_sequencer #(.CNT_BITS(8), .BEEP_COUNT(2), .ON_TICKS(4), .OFF_TICKS(2), .TONE_DIV(1)) dut_b (
    .CLK(clk), .CLR(clr), .CE(ce), .START(start), .STOP(stop),
    .BUZ(buz_b), .LED(led_b), .BUSY(busy_b), .DONE(done_b), .DBG_STATE(st_b)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       ce;
    logic [3:0] exp;  // {buz, led, busy, done} in the cycle after the inputs
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];  // {dut_b selected, buz, led, busy, done}
  int         checks = 0;
  int         failures = 0;
  string      case_name;
  int         step;

  function automatic string rep(string c, int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  function automatic logic bit_at(string s, int i);
    return (s[i] == "1");
  endfunction

  task automatic load_case(string st, string sp, string cen, string bz, string ld,
                           string bs, string dn);
    vec_t v;
    vecs.delete();
    for (int i = 0; i < st.len(); i++) begin
      v.start = bit_at(st, i);
      v.stop  = bit_at(sp, i);
      v.ce    = bit_at(cen, i);
      v.exp   = {bit_at(bz, i), bit_at(ld, i), bit_at(bs, i), bit_at(dn, i)};
      vecs.push_back(v);
    end
  endtask

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end
  endtask

  // Scoreboard: pop one expectation per cycle once the DUT has produced it
  task automatic sb_check();
    logic [4:0] e;
    logic [3:0] got;
    if (exp_q.size() == 0) return;
    e   = exp_q.pop_front();
    got = e[4] ? {buz_b, led_b, busy_b, done_b} : {buz_a, led_a, busy_a, done_a};
    checks++;
    if (got !== e[3:0]) begin
      failures++;
      $display("FAIL %s step %0d: buz/led/busy/done got %b required %b",
               case_name, step, got, e[3:0]);
    end
    step++;
  endtask

  // Driver: one vector per cycle, inputs changed on the falling edge
  task automatic run_case(string name, logic sel);
    case_name = name;
    step = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      sb_check();
      start = vecs[i].start;
      stop  = vecs[i].stop;
      ce    = vecs[i].ce;
      exp_q.push_back({sel, vecs[i].exp});
    end
    @(negedge clk);
    sb_check();
    start = 1'b0;
    stop  = 1'b0;
    ce    = 1'b0;
  endtask

  task automatic prep();
    @(negedge clk);
    stop = 1'b1;
    ce   = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    ce   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; ce = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_a", {4'd0, buz_a, led_a, busy_a, done_a}, 8'd0);
    chk("reset_outs_b", {4'd0, buz_b, led_b, busy_b, done_b}, 8'd0);
    chk("reset_state_a", {6'd0, st_a}, 8'd0);
    clr = 1'b1;
    @(negedge clk);

    load_case({"1", rep("0", 10)}, rep("0", 11), rep("1", 11),
              "00100001000", "11100111000", "11111111000", "00000000100");
    run_case("basic", 1'b0);

    prep();
    load_case({"1", rep("0", 11)}, rep("0", 12), rep("1", 12),
              "010100010100", "111100111100", "111111111100", "000000000010");
    run_case("tone", 1'b1);

    prep();
    load_case({"1", rep("0", 31)}, rep("0", 32), rep("0100", 8),
              {"001100110", rep("0", 8), "001100110011", "000"},
              {rep("1", 9), rep("0", 8), rep("1", 12), "000"},
              {rep("1", 29), "000"},
              {rep("0", 29), "100"});
    run_case("tick_gating", 1'b0);

    prep();
    load_case("1000000000", "0000010000", rep("1", 10),
              "0010000000", "1110000000", "1111100000", rep("0", 10));
    run_case("abort", 1'b0);

    prep();
    load_case("1000010000", "0000010000", rep("1", 10),
              "0010000000", "1110000000", "1111100000", rep("0", 10));
    run_case("abort_with_start", 1'b0);

    prep();
    load_case("100000010000000000", rep("0", 18), rep("1", 18),
              "001000000100001000", "111001111100111000",
              {rep("1", 15), "000"}, {rep("0", 15), "100"});
    run_case("retrigger", 1'b0);

    prep();
    load_case({"1", rep("0", 7), "1", rep("0", 9)}, rep("0", 18), rep("1", 18),
              "001000010010000100", "111001111110011100",
              {rep("1", 16), "00"}, {rep("0", 16), "10"});
    run_case("start_at_completion", 1'b0);

    // Asynchronous reset in the middle of the first beep
    prep();
    @(negedge clk);
    start = 1'b1;
    ce    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_led", {7'd0, led_a}, 8'd1);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("async_reset_outs_a", {4'd0, buz_a, led_a, busy_a, done_a}, 8'd0);
    chk("async_reset_outs_b", {4'd0, buz_b, led_b, busy_b, done_b}, 8'd0);
    chk("async_reset_state_a", {6'd0, st_a}, 8'd0);
    @(negedge clk);
    #1 clr = 1'b1;
    load_case("00000100", rep("0", 8), rep("1", 8),
              "00000001", "00000111", "00000111", rep("0", 8));
    run_case("post_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
